operand_fetch: RTL and testbench
================================

OPERAND_FETCH -- requirements
Module: operand_fetch

Interface
REQ-001 The module SHALL have these ports, one per line: name, direction, width, meaning.
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- instr  in  32  IF/ID instruction word.
- instr_valid  in  1  instr holds a real instruction.
- reg2loc  in  1  1: second source is instr[4:0] (CBZ/STUR); 0: second source is instr[20:16].
- ReadRegister1  out  5  regfile port-1 address, equal to instr[9:5].
- ReadRegister2  out  5  regfile port-2 address, chosen by reg2loc.
- ReadData1, ReadData2  in  64  regfile read data.
- ex_RegWrite, ex_MemRead  in  1  instruction in EX writes a register / is a load.
- ex_Rd  in  5  EX destination register.
- ex_result  in  64  EX ALU output.
- mem_RegWrite  in  1  instruction in MEM writes a register.
- mem_Rd  in  5  MEM destination register.
- mem_result  in  64  MEM writeback value.
- flush  in  1  taken branch; kill the ID instruction.
- stall  out  1  hold PC and IF/ID this cycle.
- idex_valid  out  1  ID/EX register holds a live instruction.
- idex_A, idex_B  out  64  forwarded operands.
- idex_Rd  out  5  instr[4:0] captured.
- stall_count  out  32  saturating count of load-use stall cycles.

Function
REQ-002 ReadRegister1 and ReadRegister2 SHALL be combinational functions of instr and reg2loc.
REQ-003 Operand selection, in priority order: source == 31 -> zero; ex_RegWrite && ex_Rd == source && ex_Rd != 31 -> ex_result; mem_RegWrite && mem_Rd == source && mem_Rd != 31 -> mem_result; otherwise ReadData.
REQ-004 WB-stage writes SHALL NOT be forwarded, because the register file writes on the falling edge and returns the new value in the same cycle.
REQ-005 A hazard SHALL be flagged when instr_valid && ex_MemRead && ex_Rd != 31 && ex_Rd matches either source.
REQ-006 The FSM SHALL have two states, RUN and BUBBLE. In RUN, a hazard without flush asserts stall combinationally and moves the FSM to BUBBLE. BUBBLE always returns to RUN. In BUBBLE, stall is 0.
REQ-007 Each rising edge SHALL load the ID/EX register with one-cycle latency: idex_valid = instr_valid && !stall && !flush; the A, B and Rd values are captured from the selected operands.
REQ-008 In a stalled cycle the ID/EX register SHALL load a bubble (idex_valid = 0, data fields = 0).
REQ-009 flush SHALL take precedence over a hazard: stall = 0, idex_valid = 0, and the next state is RUN.
REQ-010 stall_count SHALL increment once per cycle in which stall = 1, and SHALL saturate at 0xFFFF_FFFF.
REQ-011 When both ex and mem match the same source, ex_result SHALL win.

Reset
REQ-012 While rst_n = 0: state = RUN; idex_valid, idex_A, idex_B, idex_Rd and stall_count are 0.
REQ-013 Reset asserted mid-stall SHALL abandon the bubble, with no residual stall after release.

Structure
REQ-014 Package cpu_pkg SHALL hold: the XZR constant (31), the field positions (RD_LSB 0, RN_LSB 5, RM_LSB 16), and the state enum {RUN, BUBBLE}.
REQ-015 The per-operand priority selection SHALL be a sub-module, fwd_sel, instantiated twice.

Verification
REQ-016 The bench SHALL cover these directed scenarios:
- instr Rn=3, Rm=4; ReadData1 = 0x11, ReadData2 = 0x22; no matches -> next cycle idex_A = 0x11, idex_B = 0x22, idex_valid = 1.
- ex_RegWrite, ex_Rd = 3, ex_result = 0xAA; mem_RegWrite, mem_Rd = 3, mem_result = 0xBB -> idex_A = 0xAA.
- Rn = 31 with ex_Rd = 31, ex_RegWrite = 1 -> idex_A = 0.
- ex_MemRead, ex_Rd = 4, Rm = 4 -> stall = 1 for one cycle, bubble in ID/EX, stall_count = 1; next cycle mem_Rd = 4 supplies idex_B.
- Hazard plus flush in the same cycle -> stall = 0, idex_valid = 0, stall_count unchanged.
- rst_n dropped during BUBBLE -> all outputs 0 immediately; after release a repeated load-use produces exactly one stall.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared constants and state encoding for the ID-stage operand fetch logic.
package cpu_pkg;

  localparam int         REG_W  = 5;
  localparam logic [4:0] XZR    = 5'd31;
  localparam int         RD_LSB = 0;
  localparam int         RN_LSB = 5;
  localparam int         RM_LSB = 16;

  typedef enum logic {
    RUN    = 1'b0,
    BUBBLE = 1'b1
  } state_e;

endpackage

// File: rtl/fwd_sel.sv
// Priority operand select for one source register: XZR, then EX, then MEM, then regfile.
module fwd_sel
  import cpu_pkg::*;
#(
  parameter int DATA_W = 64
) (
  input  logic [REG_W-1:0]  i_src,
  input  logic [DATA_W-1:0] i_rdata,
  input  logic              i_ex_we,
  input  logic [REG_W-1:0]  i_ex_rd,
  input  logic [DATA_W-1:0] i_ex_res,
  input  logic              i_mem_we,
  input  logic [REG_W-1:0]  i_mem_rd,
  input  logic [DATA_W-1:0] i_mem_res,
  output logic [DATA_W-1:0] o_operand
);

  logic w_ex_hit;
  logic w_mem_hit;

  assign w_ex_hit  = i_ex_we  && (i_ex_rd  == i_src) && (i_ex_rd  != XZR);
  assign w_mem_hit = i_mem_we && (i_mem_rd == i_src) && (i_mem_rd != XZR);

  // WB is never forwarded: the regfile writes on the falling edge, so ReadData already has it.
  always_comb begin
    o_operand = i_rdata;
    if (i_src == XZR) begin
      o_operand = '0;
    end else if (w_ex_hit) begin
      o_operand = i_ex_res;
    end else if (w_mem_hit) begin
      o_operand = i_mem_res;
    end
  end

endmodule

// File: rtl/operand_fetch.sv
// ID stage: register address decode, EX/MEM forwarding, load-use stall FSM and ID/EX register.
module operand_fetch
  import cpu_pkg::*;
#(
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [31:0]       instr,
  input  logic              instr_valid,
  input  logic              reg2loc,
  output logic [REG_W-1:0]  ReadRegister1,
  output logic [REG_W-1:0]  ReadRegister2,
  input  logic [DATA_W-1:0] ReadData1,
  input  logic [DATA_W-1:0] ReadData2,
  input  logic              ex_RegWrite,
  input  logic              ex_MemRead,
  input  logic [REG_W-1:0]  ex_Rd,
  input  logic [DATA_W-1:0] ex_result,
  input  logic              mem_RegWrite,
  input  logic [REG_W-1:0]  mem_Rd,
  input  logic [DATA_W-1:0] mem_result,
  input  logic              flush,
  output logic              stall,
  output logic              idex_valid,
  output logic [DATA_W-1:0] idex_A,
  output logic [DATA_W-1:0] idex_B,
  output logic [REG_W-1:0]  idex_Rd,
  output logic [31:0]       stall_count
);

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  state_e            r_state;
  logic              r_vld_p1;
  logic [DATA_W-1:0] r_a_p1;
  logic [DATA_W-1:0] r_b_p1;
  logic [REG_W-1:0]  r_rd_p1;
  logic [31:0]       r_stall_cnt;

  logic [DATA_W-1:0] w_op_a_p0;
  logic [DATA_W-1:0] w_op_b_p0;
  logic              w_hazard;
  logic              w_unused;

  // Opcode and shamt bits are decoded elsewhere in the pipeline.
  assign w_unused = ^{instr[31:21], instr[15:10]};

  // ---- p0: decode, forward, hazard detect ----
  assign ReadRegister1 = instr[RN_LSB +: REG_W];
  assign ReadRegister2 = reg2loc ? instr[RD_LSB +: REG_W] : instr[RM_LSB +: REG_W];

  assign w_hazard = instr_valid && ex_MemRead && (ex_Rd != XZR) &&
                    ((ex_Rd == ReadRegister1) || (ex_Rd == ReadRegister2));

  // Only one bubble per load: in BUBBLE the load has moved on to MEM and is forwarded from there.
  assign stall = (r_state == RUN) && w_hazard && !flush;

  fwd_sel #(.DATA_W(DATA_W)) u_fwd_a (
    .i_src     (ReadRegister1),
    .i_rdata   (ReadData1),
    .i_ex_we   (ex_RegWrite),
    .i_ex_rd   (ex_Rd),
    .i_ex_res  (ex_result),
    .i_mem_we  (mem_RegWrite),
    .i_mem_rd  (mem_Rd),
    .i_mem_res (mem_result),
    .o_operand (w_op_a_p0)
  );

  fwd_sel #(.DATA_W(DATA_W)) u_fwd_b (
    .i_src     (ReadRegister2),
    .i_rdata   (ReadData2),
    .i_ex_we   (ex_RegWrite),
    .i_ex_rd   (ex_Rd),
    .i_ex_res  (ex_result),
    .i_mem_we  (mem_RegWrite),
    .i_mem_rd  (mem_Rd),
    .i_mem_res (mem_result),
    .o_operand (w_op_b_p0)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= RUN;
    end else begin
      case (r_state)
        RUN:     r_state <= stall ? BUBBLE : RUN;
        BUBBLE:  r_state <= RUN;
        default: r_state <= RUN;
      endcase
    end
  end

  // ---- p1: ID/EX register ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld_p1    <= 1'b0;
      r_a_p1      <= '0;
      r_b_p1      <= '0;
      r_rd_p1     <= '0;
      r_stall_cnt <= '0;
    end else begin
      r_vld_p1 <= instr_valid && !stall && !flush;
      if (stall) begin
        r_a_p1      <= '0;
        r_b_p1      <= '0;
        r_rd_p1     <= '0;
        r_stall_cnt <= sat_inc(r_stall_cnt);
      end else begin
        r_a_p1  <= w_op_a_p0;
        r_b_p1  <= w_op_b_p0;
        r_rd_p1 <= instr[RD_LSB +: REG_W];
      end
    end
  end

  assign idex_valid  = r_vld_p1;
  assign idex_A      = r_a_p1;
  assign idex_B      = r_b_p1;
  assign idex_Rd     = r_rd_p1;
  assign stall_count = r_stall_cnt;

endmodule

// File: tb/tb_operand_fetch.sv
// Scoreboard bench for operand_fetch: directed scenarios plus randomized traffic vs a reference model.
module tb_operand_fetch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] instr;
  logic        instr_valid, reg2loc;
  logic [4:0]  ReadRegister1, ReadRegister2;
  logic [63:0] ReadData1, ReadData2;
  logic        ex_RegWrite, ex_MemRead;
  logic [4:0]  ex_Rd;
  logic [63:0] ex_result;
  logic        mem_RegWrite;
  logic [4:0]  mem_Rd;
  logic [63:0] mem_result;
  logic        flush, stall, idex_valid;
  logic [63:0] idex_A, idex_B;
  logic [4:0]  idex_Rd;
  logic [31:0] stall_count;

  always #5 clk = ~clk;

  operand_fetch dut (
    .clk(clk), .rst_n(rst_n), .instr(instr), .instr_valid(instr_valid), .reg2loc(reg2loc),
    .ReadRegister1(ReadRegister1), .ReadRegister2(ReadRegister2),
    .ReadData1(ReadData1), .ReadData2(ReadData2),
    .ex_RegWrite(ex_RegWrite), .ex_MemRead(ex_MemRead), .ex_Rd(ex_Rd), .ex_result(ex_result),
    .mem_RegWrite(mem_RegWrite), .mem_Rd(mem_Rd), .mem_result(mem_result),
    .flush(flush), .stall(stall), .idex_valid(idex_valid), .idex_A(idex_A), .idex_B(idex_B),
    .idex_Rd(idex_Rd), .stall_count(stall_count)
  );

  typedef struct packed {
    logic [31:0] instr;
    logic        iv, r2l;
    logic [63:0] rd1, rd2;
    logic        exw, exm;
    logic [4:0]  exrd;
    logic [63:0] exres;
    logic        memw;
    logic [4:0]  memrd;
    logic [63:0] memres;
    logic        fl;
  } stim_t;

  typedef struct packed {
    logic        v;
    logic [63:0] a, b;
    logic [4:0]  rd;
    logic [31:0] cnt;
  } exp_t;

  exp_t        q[$];
  int          errors = 0;
  int          checks = 0;
  bit          m_bub;
  logic [31:0] m_cnt;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic stim_t idle();
    stim_t x;
    x = '0;
    return x;
  endfunction

  function automatic logic [31:0] mk(input logic [4:0] rn, input logic [4:0] rm, input logic [4:0] rd);
    return {11'h5A3, rm, 6'h15, rn, rd};
  endfunction

  // Architectural view: the value a source register holds once older in-flight writes are visible.
  function automatic logic [63:0] m_op(input logic [4:0] s, input logic [63:0] rf, input stim_t x);
    if (s == 5'd31)                   return 64'd0;
    if (x.exw && x.exrd == s)         return x.exres;
    if (x.memw && x.memrd == s)       return x.memres;
    return rf;
  endfunction

  task automatic apply(input stim_t x);
    instr = x.instr; instr_valid = x.iv; reg2loc = x.r2l;
    ReadData1 = x.rd1; ReadData2 = x.rd2;
    ex_RegWrite = x.exw; ex_MemRead = x.exm; ex_Rd = x.exrd; ex_result = x.exres;
    mem_RegWrite = x.memw; mem_Rd = x.memrd; mem_result = x.memres; flush = x.fl;
  endtask

  task automatic model_reset();
    m_bub = 1'b0;
    m_cnt = 32'd0;
    q.delete();
  endtask

  // One clock: drive at negedge, predict, return just after the capturing edge.
  task automatic cyc(input stim_t x);
    logic [4:0] s1, s2;
    bit         haz, st;
    exp_t       e;
    @(negedge clk);
    apply(x);
    s1  = x.instr[9:5];
    s2  = x.r2l ? x.instr[4:0] : x.instr[20:16];
    haz = x.iv && x.exm && x.exrd != 5'd31 && (x.exrd == s1 || x.exrd == s2);
    st  = haz && !x.fl && !m_bub;
    e.v   = x.iv && !st && !x.fl;
    e.a   = st ? 64'd0 : m_op(s1, x.rd1, x);
    e.b   = st ? 64'd0 : m_op(s2, x.rd2, x);
    e.rd  = st ? 5'd0 : x.instr[4:0];
    e.cnt = (st && m_cnt != 32'hFFFF_FFFF) ? m_cnt + 32'd1 : m_cnt;
    m_cnt = e.cnt;
    m_bub = st;
    q.push_back(e);
    #1;
    chk("ReadRegister1", ReadRegister1, s1);
    chk("ReadRegister2", ReadRegister2, s2);
    chk("stall", stall, st);
    @(posedge clk);
    #2;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (rst_n && q.size() > 0) begin
        e = q.pop_front();
        chk("idex_valid", idex_valid, e.v);
        chk("idex_A", idex_A, e.a);
        chk("idex_B", idex_B, e.b);
        chk("idex_Rd", idex_Rd, e.rd);
        chk("stall_count", stall_count, e.cnt);
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: time limit reached, got no finish expected finish");
    $fatal(1, "timeout");
  end

  function automatic logic [4:0] pick();
    int r;
    r = $urandom_range(0, 7);
    return (r >= 6) ? 5'd31 : 5'(r);
  endfunction

  initial begin : stim
    stim_t x;
    rst_n = 1'b0;
    apply(idle());
    model_reset();
    #1;
    chk("reset idex_valid", idex_valid, 0);
    chk("reset idex_A", idex_A, 0);
    chk("reset idex_B", idex_B, 0);
    chk("reset idex_Rd", idex_Rd, 0);
    chk("reset stall_count", stall_count, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Plain regfile read
    x = idle(); x.instr = mk(5'd3, 5'd4, 5'd7); x.iv = 1; x.rd1 = 64'h11; x.rd2 = 64'h22;
    cyc(x);
    chk("dir plain A", idex_A, 64'h11);
    chk("dir plain B", idex_B, 64'h22);
    chk("dir plain valid", idex_valid, 1);

    // EX beats MEM on the same source
    x.exw = 1; x.exrd = 5'd3; x.exres = 64'hAA; x.memw = 1; x.memrd = 5'd3; x.memres = 64'hBB;
    cyc(x);
    chk("dir ex-over-mem A", idex_A, 64'hAA);

    // XZR never forwarded
    x = idle(); x.instr = mk(5'd31, 5'd4, 5'd2); x.iv = 1; x.rd1 = 64'h77;
    x.exw = 1; x.exrd = 5'd31; x.exres = 64'h55;
    cyc(x);
    chk("dir xzr A", idex_A, 64'd0);

    // Load-use: one bubble, then MEM forwards the loaded value
    x = idle(); x.instr = mk(5'd1, 5'd4, 5'd9); x.iv = 1; x.rd2 = 64'h22;
    x.exw = 1; x.exm = 1; x.exrd = 5'd4; x.exres = 64'h99;
    cyc(x);
    chk("dir loaduse valid", idex_valid, 0);
    chk("dir loaduse count", stall_count, 1);
    x.exw = 0; x.exm = 0; x.exrd = 5'd0; x.memw = 1; x.memrd = 5'd4; x.memres = 64'h44;
    cyc(x);
    chk("dir after-stall B", idex_B, 64'h44);
    chk("dir after-stall valid", idex_valid, 1);

    // Hazard with flush: no stall, no valid, count unchanged
    x = idle(); x.instr = mk(5'd1, 5'd4, 5'd9); x.iv = 1; x.fl = 1;
    x.exw = 1; x.exm = 1; x.exrd = 5'd4;
    cyc(x);
    chk("dir flush valid", idex_valid, 0);
    chk("dir flush count", stall_count, 1);

    // Reset during BUBBLE
    x.fl = 0;
    cyc(x);
    chk("dir pre-reset count", stall_count, 2);
    @(negedge clk);
    rst_n = 1'b0;
    apply(idle());
    model_reset();
    #1;
    chk("midreset stall", stall, 0);
    chk("midreset idex_valid", idex_valid, 0);
    chk("midreset idex_A", idex_A, 0);
    chk("midreset idex_B", idex_B, 0);
    chk("midreset idex_Rd", idex_Rd, 0);
    chk("midreset stall_count", stall_count, 0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc(x);
    cyc(x);
    x.exm = 0; x.exw = 0;
    cyc(x);
    chk("post-reset single stall", stall_count, 1);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      x = idle();
      x.instr  = $urandom;
      x.instr[9:5]   = pick();
      x.instr[20:16] = pick();
      x.instr[4:0]   = pick();
      x.iv     = ($urandom_range(0, 9) != 0);
      x.r2l    = $urandom_range(0, 1);
      x.rd1    = {$urandom, $urandom};
      x.rd2    = {$urandom, $urandom};
      x.exm    = ($urandom_range(0, 2) == 0);
      x.exw    = x.exm || ($urandom_range(0, 1) == 1);
      x.exrd   = pick();
      x.exres  = {$urandom, $urandom};
      x.memw   = $urandom_range(0, 1);
      x.memrd  = pick();
      x.memres = {$urandom, $urandom};
      x.fl     = ($urandom_range(0, 7) == 0);
      cyc(x);
    end

    @(negedge clk);
    apply(idle());
    @(posedge clk);
    #3;
    chk("scoreboard drained", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
